// File: rtl/instr_mem.sv
// Byte-addressed instruction memory for the 24-bit single-cycle CPU.
// Combinational big-endian 3-byte fetch, synchronous byte-write load port, async reset to identity image.
module instr_mem #(
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 24,
    parameter int INSTR_W = 24
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               AddrFault,
    input  logic               WrEn,
    input  logic [ADDR_W-1:0]  WrAddr,
    input  logic [7:0]         WrData
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so PC+2 near the top of the address space cannot wrap into range.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    logic [ADDR_W:0] byte_addr [3];
    logic            byte_ok   [3];
    logic [7:0]      rd_byte   [3];
    logic            wr_ok;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            byte_addr[i] = {1'b0, PC} + (ADDR_W+1)'(i);
            byte_ok[i]   = (byte_addr[i] < DEPTH_X);
            rd_byte[i]   = byte_ok[i] ? mem_q[byte_addr[i][IDX_W-1:0]] : 8'h00;
        end
        Instruction = {rd_byte[0], rd_byte[1], rd_byte[2]};
        AddrFault   = !byte_ok[2];
    end

    always_comb begin
        wr_ok = WrEn && ({1'b0, WrAddr} < DEPTH_X);
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[WrAddr[IDX_W-1:0]] = WrData;
        end
    end

    // Reset is asynchronous, so the default image appears without waiting for a clock edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= 8'(k);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// Directed + randomized checks of instr_mem: reset image, fetch alignment, range faults, byte writes, async reset.
module tb_instr_mem;

    logic        Clock;
    logic        Reset;
    logic [23:0] PC;
    logic [23:0] Instruction;
    logic        AddrFault;
    logic        WrEn;
    logic [23:0] WrAddr;
    logic [7:0]  WrData;

    int n_assert = 0;
    int n_fail   = 0;

    logic [24:0] exp_q[$];
    logic [7:0]  model_mem [128];

    instr_mem #(.DEPTH(128), .ADDR_W(24), .INSTR_W(24)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PC         (PC),
        .Instruction(Instruction),
        .AddrFault  (AddrFault),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrData     (WrData)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic model_reset();
        for (int k = 0; k < 128; k++) model_mem[k] = 8'(k);
    endtask

    function automatic logic [24:0] model_fetch(input logic [23:0] pc);
        logic [24:0] a;
        logic [7:0]  b [3];
        for (int i = 0; i < 3; i++) begin
            a    = {1'b0, pc} + 25'(i);
            b[i] = (a < 25'd128) ? model_mem[a[6:0]] : 8'h00;
        end
        a = {1'b0, pc} + 25'd2;
        return {(a >= 25'd128), b[0], b[1], b[2]};
    endfunction

    // scoreboard compare: pops one expected {fault, instr}
    task automatic check(input string tag);
        logic [24:0] exp;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard queue empty, got %h", tag, {AddrFault, Instruction});
        end else begin
            exp = exp_q.pop_front();
            assert ({AddrFault, Instruction} === exp) else begin
                n_fail++;
                $error("FAIL %s: got fault=%b instr=%h, expected fault=%b instr=%h",
                       tag, AddrFault, Instruction, exp[24], exp[23:0]);
            end
        end
    endtask

    // driver: present PC away from the clock edge and compare
    task automatic read_pc(input logic [23:0] pc, input logic [24:0] exp, input string tag);
        @(negedge Clock);
        PC = pc;
        exp_q.push_back(exp);
        #1;
        check(tag);
    endtask

    task automatic write_byte(input logic [23:0] addr, input logic [7:0] data);
        @(negedge Clock);
        WrEn   = 1'b1;
        WrAddr = addr;
        WrData = data;
        @(posedge Clock);
        #1;
        WrEn = 1'b0;
        if (Reset && addr < 24'd128) model_mem[addr[6:0]] = data;
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] p;
        logic [7:0]  d;

        Reset  = 1'b0;
        PC     = 24'd0;
        WrEn   = 1'b0;
        WrAddr = 24'd0;
        WrData = 8'd0;
        model_reset();

        // reset held low: default image visible, writes ignored
        read_pc(24'd7, {1'b0, 24'h070809}, "reset_low_pc7");
        write_byte(24'd7, 8'h55);
        read_pc(24'd7, {1'b0, 24'h070809}, "reset_low_write_ignored");

        @(negedge Clock);
        Reset = 1'b1;

        read_pc(24'd7,       {1'b0, 24'h070809}, "pc7");
        read_pc(24'd0,       {1'b0, 24'h000102}, "pc0");
        read_pc(24'd125,     {1'b0, 24'h7D7E7F}, "pc125");
        read_pc(24'd126,     {1'b1, 24'h7E7F00}, "pc126");
        read_pc(24'd127,     {1'b1, 24'h7F0000}, "pc127");
        read_pc(24'd128,     {1'b1, 24'h000000}, "pc128");
        read_pc(24'hFFFFFF,  {1'b1, 24'h000000}, "pc_ffffff");
        read_pc(24'hFFFFFE,  {1'b1, 24'h000000}, "pc_fffffe");

        // write addr 8: old byte before edge, new byte after
        @(negedge Clock);
        PC     = 24'd7;
        WrEn   = 1'b1;
        WrAddr = 24'd8;
        WrData = 8'hAB;
        #1;
        exp_q.push_back({1'b0, 24'h070809});
        check("before_edge");
        @(posedge Clock);
        #1;
        WrEn = 1'b0;
        model_mem[8] = 8'hAB;
        exp_q.push_back({1'b0, 24'h07AB09});
        check("after_edge");

        // out-of-range write dropped, no aliasing into low addresses
        write_byte(24'd200, 8'hFF);
        read_pc(24'd7,  {1'b0, 24'h07AB09}, "oob_write_pc7");
        read_pc(24'd72, {1'b0, 24'h48494A}, "oob_write_alias72");
        write_byte(24'h800008, 8'h11);
        read_pc(24'd6,  {1'b0, 24'h0607AB}, "oob_write_hi_alias");

        // random writes then random fetches against the model
        for (int i = 0; i < 40; i++) begin
            a = 24'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            write_byte(a, d);
        end
        for (int i = 0; i < 40; i++) begin
            p = 24'($urandom_range(0, 131));
            read_pc(p, model_fetch(p), "rand_fetch");
        end

        // async reset between edges restores image immediately
        write_byte(24'd8, 8'hC3);
        @(posedge Clock);
        #2;
        PC    = 24'd7;
        Reset = 1'b0;
        model_reset();
        #1;
        exp_q.push_back({1'b0, 24'h070809});
        check("async_reset_immediate");
        write_byte(24'd8, 8'h99);
        read_pc(24'd7, {1'b0, 24'h070809}, "async_reset_write_ignored");
        @(negedge Clock);
        Reset = 1'b1;
        read_pc(24'd7, model_fetch(24'd7), "post_reset_pc7");
        write_byte(24'd9, 8'h5A);
        read_pc(24'd7, {1'b0, 24'h07085A}, "post_reset_write");

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule
